uart_tx_buffered: RTL and testbench
===================================

Name: uart_tx_buffered

Overview:
Buffered UART transmitter. Accepts bytes over a valid/ready handshake into a small FIFO and serializes them on `tx` as 8N1 frames, LSB first. It is the transmit-side counterpart to the existing `uart_receive`, and drives a line that a `uart_receive` instance can sample directly. Used where the producer cannot hold `dataReady` stable for a whole frame.

Parameters:
- CLK_HZ, 5_000_000, system clock frequency in Hz
- BAUD, 9600, line rate in bits/s
- DEPTH, 4, FIFO entries; power of two, minimum 2

Ports:
- clock  input  1  system clock; all logic on the rising edge
- reset  input  1  synchronous, active-high reset
- data_in  input  8  byte to enqueue
- data_valid  input  1  producer offers `data_in` this cycle
- data_ready  output  1  FIFO can accept a byte this cycle
- tx  output  1  serial line; idle high
- busy  output  1  high while a frame is on the line (start through stop)
- fifo_count  output  $clog2(DEPTH)+1  bytes currently queued, excluding the byte in flight

Behaviour:
- Clock and reset: single clock `clock`. Reset `reset` is synchronous and active-high. Both are fixed.
- Bit period: DIV = CLK_HZ/BAUD, integer truncated (520 at defaults). Every bit, including start and stop, lasts exactly DIV cycles. The baud counter is 0..DIV-1 and restarts at every bit boundary.
- Reset values: `tx`=1, `busy`=0, `data_ready`=1, `fifo_count`=0, state=IDLE. FIFO pointers and bit counter are cleared.
- Reset mid-frame: the frame is abandoned, `tx` is 1 on the cycle after the reset edge, and the FIFO contents are discarded.
- Handshake: a push occurs on each cycle where `data_valid`=1 and `data_ready`=1. `data_ready` = (fifo_count < DEPTH); it is combinational from registered count. `data_in` is ignored when no push occurs.
- Full FIFO: `data_ready`=0 even if a pop happens the same cycle (no write-through). A `data_valid` with `data_ready`=0 is dropped; it is the producer's duty to hold it.
- Empty FIFO: a pop requires fifo_count>0 at the start of the cycle. A push into an empty FIFO is not popped in the same cycle.
- Simultaneous push and pop: `fifo_count` is unchanged.
- State machine IDLE, START, DATA, STOP (plus PARITY when enabled):
  - IDLE: `tx`=1, `busy`=0. If fifo_count>0, pop the head into the shift register and go to START. `tx` falls on the next cycle.
  - START: `tx`=0 for DIV cycles, then DATA with bit index 0.
  - DATA: `tx`=shift[idx] for DIV cycles each, idx 0..7 (LSB first). After idx 7, go to STOP (or PARITY).
  - STOP: `tx`=1 for DIV cycles, then IDLE.
  - `busy`=1 in START, DATA, PARITY and STOP.
- Back-to-back frames: after STOP, exactly one IDLE cycle occurs before the next START. Frame pitch is 10*DIV+1 cycles (11*DIV+1 with parity).
- `tx` is driven from a register, so it is glitch-free.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for DIV cycles. Frame is 8E1, 11 bits.
- Undefined: no PARITY state and no parity logic; frame is 8N1, 10 bits.
- Ports and parameters are identical in both builds.

Test Plan:
- Reset and idle: hold `reset`=1 for 3 cycles, then release. Required: `tx`=1, `busy`=0, `data_ready`=1, `fifo_count`=0 for 100 idle cycles.
- Single byte, CLK_HZ=16, BAUD=1 (DIV=16): push 0xA5. Required: `tx` low 16 cycles after the pop cycle, then bits 1,0,1,0,0,1,0,1 at 16 cycles each, then high 16. `busy` high for 160 cycles. A `uart_receive` model decodes 0xA5.
- Fill/full: push 0x01..0x05 on consecutive cycles with `data_valid` held. Required: 0x01 is popped, and 0x02..0x05 fill the FIFO to fifo_count=4 with `data_ready`=0. Further pushes stall until the next pop. Wire order is 01,02,03,04,05. Frame starts are spaced 161 cycles apart.
- Simultaneous push/pop: with fifo_count=DEPTH-1, push on the IDLE pop cycle. Required: fifo_count is unchanged that cycle.
- Reset mid-frame: assert `reset` during DATA idx 3 with 2 bytes queued. Required: next cycle `tx`=1, `busy`=0, `fifo_count`=0, and no further frames are sent.
- Parity build (UART_TX_PARITY_EN), DIV=16: send 0x07. Required: parity bit 1 appears after the data bits, and `busy` lasts 176 cycles.

Source files
------------

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: byte FIFO in front of an 8N1 serializer, LSB first, idle-high line.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit (8E1).
module uart_tx_buffered #(
    parameter int CLK_HZ = 5_000_000,
    parameter int BAUD   = 9600,
    parameter int DEPTH  = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               data_in,
    input  logic                     data_valid,
    output logic                     data_ready,
    output logic                     tx,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int DIV     = CLK_HZ / BAUD;
    localparam int BAUD_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int COUNT_W = PTR_W + 1;

    localparam logic [BAUD_W-1:0]  BAUD_LAST = BAUD_W'(DIV - 1);
    localparam logic [COUNT_W-1:0] DEPTH_C   = COUNT_W'(DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             state;
    logic [7:0]         mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [7:0]         shift;
    logic [2:0]         bit_idx;
    logic [BAUD_W-1:0]  baud_cnt;
    logic               bit_end;
    logic               push;
    logic               pop;

    // A full FIFO refuses data even when a pop happens in the same cycle.
    assign data_ready = (fifo_count < DEPTH_C);
    assign push       = data_valid && data_ready;
    assign pop        = (state == IDLE) && (fifo_count != '0);
    assign bit_end    = (baud_cnt == BAUD_LAST);

    // NOTE: storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // NOTE: non-blocking assignments keep every register reading pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + COUNT_W'(1);
                2'b01:   fifo_count <= fifo_count - COUNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            tx       <= 1'b1;
            busy     <= 1'b0;
            shift    <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
        end else begin
            // The baud counter runs only inside a frame and wraps at each bit boundary.
            if (state == IDLE || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end

            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= PARITY;
                            tx    <= ^shift;
`else
                            state <= STOP;
                            tx    <= 1'b1;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[bit_idx + 3'd1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_end) begin
                        state <= STOP;
                        tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (bit_end) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at DIV=16 with a line-sampling receiver model.
module tb_uart_tx_buffered;

    localparam int CLK_HZ = 16;
    localparam int BAUD   = 1;
    localparam int DEPTH  = 4;
    localparam int DIV    = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int PITCH = FRAME_BITS * DIV + 1;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] rx_q[$];
    int         start_q[$];
    int         frame_errs = 0;
    bit         rx_active  = 1'b0;
    int         rx_t;
    logic [7:0] rx_sh;

    uart_tx_buffered #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    // Receiver model: finds the start bit, samples each bit mid-period.
    always @(negedge clock) begin : rx_model
        int j;
        if (reset === 1'b1) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_t      = 0;
                start_q.push_back(cyc);
            end
        end else begin
            rx_t++;
            if (rx_t % DIV == DIV / 2) begin
                j = rx_t / DIV;
                if (j >= 1 && j <= 8) begin
                    rx_sh[j-1] = tx;
                end else if (FRAME_BITS == 11 && j == 9) begin
                    if (tx !== ^rx_sh) frame_errs++;
                end else if (j == FRAME_BITS - 1) begin
                    if (tx !== 1'b1) frame_errs++;
                    rx_q.push_back(rx_sh);
                    rx_active = 1'b0;
                end
            end
        end
    end

    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (FRAME_BITS == 11 && j == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic wait_busy_low(input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < 400) begin
            tick();
            n++;
        end
        check(tag, 32'(busy), 0);
    endtask

    task automatic wait_rx(input string tag, input int n_exp);
        int n = 0;
        while (rx_q.size() < n_exp && n < n_exp * PITCH + 200) begin
            tick();
            n++;
        end
        check(tag, rx_q.size(), n_exp);
    endtask

    initial begin
        int t_pop;
        int bad;

        // Reset and idle
        reset      = 1'b1;
        data_valid = 1'b0;
        data_in    = 8'h00;
        repeat (3) tick();
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_tx",    32'(tx), 1);
            check("idle_busy",  32'(busy), 0);
            check("idle_ready", 32'(data_ready), 1);
            check("idle_count", 32'(fifo_count), 0);
        end

        // Single byte 0xA5, checked bit by bit and through the receiver model
        data_in    = 8'hA5;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        check("a5_queued", 32'(fifo_count), 1);
        check("a5_not_yet_busy", 32'(busy), 0);
        for (int k = 0; k < FRAME_BITS * DIV; k++) begin
            tick();
            check("a5_tx",   32'(tx), 32'(frame_bit(8'hA5, k / DIV)));
            check("a5_busy", 32'(busy), 1);
            if (k == 0) check("a5_popped", 32'(fifo_count), 0);
        end
        tick();
        check("a5_end_busy", 32'(busy), 0);
        check("a5_end_tx",   32'(tx), 1);
        check("a5_rx_count", rx_q.size(), 1);
        if (rx_q.size() > 0) check("a5_rx_byte", 32'(rx_q[0]), 32'h A5);

        // Fill to full with data_valid held
        rx_q.delete();
        start_q.delete();
        data_in    = 8'h01;
        data_valid = 1'b1;
        tick();
        check("fill_e0_count", 32'(fifo_count), 1);
        data_in = 8'h02;
        tick();
        t_pop = cyc;
        check("fill_pushpop_count", 32'(fifo_count), 1);
        check("fill_busy", 32'(busy), 1);
        data_in = 8'h03;
        tick();
        check("fill_e2_count", 32'(fifo_count), 2);
        data_in = 8'h04;
        tick();
        check("fill_e3_count", 32'(fifo_count), 3);
        data_in = 8'h05;
        tick();
        check("fill_full_count", 32'(fifo_count), 4);
        check("fill_full_ready", 32'(data_ready), 0);
        data_in = 8'h06;
        repeat (20) tick();
        check("stall_count", 32'(fifo_count), 4);
        check("stall_ready", 32'(data_ready), 0);
        bad = 0;
        while (data_ready !== 1'b1 && bad < 400) begin
            tick();
            bad++;
        end
        check("stall_release_time", cyc - t_pop, PITCH);
        check("stall_release_count", 32'(fifo_count), 3);
        tick();
        data_valid = 1'b0;
        check("refill_count", 32'(fifo_count), 4);
        wait_rx("fill_rx_count", 6);
        for (int i = 0; i < 6 && i < rx_q.size(); i++) begin
            check("fill_order", 32'(rx_q[i]), i + 1);
        end
        for (int i = 0; i + 1 < start_q.size() && i < 5; i++) begin
            check("fill_pitch", start_q[i+1] - start_q[i], PITCH);
        end

        // Push on the IDLE pop cycle with fifo_count = DEPTH-1
        wait_busy_low("pp_idle0");
        rx_q.delete();
        start_q.delete();
        data_in    = 8'h10;
        data_valid = 1'b1;
        tick();
        data_in = 8'h11;
        tick();
        data_in = 8'h12;
        tick();
        data_in = 8'h13;
        tick();
        data_valid = 1'b0;
        check("pp_pre_count", 32'(fifo_count), 3);
        wait_busy_low("pp_idle1");
        check("pp_idle_count", 32'(fifo_count), 3);
        data_in    = 8'h14;
        data_valid = 1'b1;
        tick();
        data_valid = 1'b0;
        check("pp_same_count", 32'(fifo_count), 3);
        check("pp_busy", 32'(busy), 1);
        check("pp_tx", 32'(tx), 0);
        wait_rx("pp_rx_count", 5);
        for (int i = 0; i < 5 && i < rx_q.size(); i++) begin
            check("pp_order", 32'(rx_q[i]), 32'h10 + i);
        end

        // Reset during DATA bit 3 with two bytes queued
        wait_busy_low("rst_idle");
        rx_q.delete();
        start_q.delete();
        data_in    = 8'h20;
        data_valid = 1'b1;
        tick();
        data_in = 8'h21;
        tick();
        data_in = 8'h22;
        tick();
        data_valid = 1'b0;
        check("rst_pre_count", 32'(fifo_count), 2);
        repeat (70) tick();
        check("rst_mid_idx3_tx", 32'(tx), 0);
        check("rst_mid_busy", 32'(busy), 1);
        reset = 1'b1;
        tick();
        check("rst_tx",    32'(tx), 1);
        check("rst_busy",  32'(busy), 0);
        check("rst_count", 32'(fifo_count), 0);
        check("rst_ready", 32'(data_ready), 1);
        tick();
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) bad++;
        end
        check("rst_no_frames", bad, 0);
        check("rst_rx_empty", rx_q.size(), 0);
        check("frame_errors", frame_errs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
